// File: rtl/infifo_dispatch.sv
// Packet write dispatcher: steers a source's packet words to one of NUM_THREADS input FIFOs (round-robin or explicit select).
// Optional macro INFIFO_WR_STRETCH_EN widens each fifowrite_out strobe to two cycles.
module infifo_dispatch #(
  parameter int NUM_THREADS = 8,
  parameter int SEL_W       = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   firstword_in,
  input  logic                   fifowrite_in,
  input  logic                   lastword_in,
  input  logic                   enable_cpu_in,
  input  logic [SEL_W-1:0]       thread_sel,
  input  logic                   auto_mode,
  input  logic [NUM_THREADS-1:0] thread_full,
  output logic [NUM_THREADS-1:0] firstword_out,
  output logic [NUM_THREADS-1:0] fifowrite_out,
  output logic [NUM_THREADS-1:0] enable_cpu_out,
  output logic                   ready_out,
  output logic [SEL_W-1:0]       cur_thread,
  output logic                   sel_err
);

  localparam int SEL_N = 2 ** SEL_W;

  typedef enum logic {IDLE, PKT} state_t;

  state_t                 state, state_nxt;
  logic [SEL_W-1:0]       rr_ptr, tgt, cand, rot_idx;
  logic                   auto_latched;
  logic [SEL_N-1:0]       full_pad;
  logic                   cand_ok, accept, start, pkt_end, bad_start, advance_rr;
  logic [NUM_THREADS-1:0] cand_hot, rot_hot, strobe, first_strobe;

  // Selects beyond NUM_THREADS read as full so they can never be accepted.
  always_comb begin
    full_pad                  = '1;
    full_pad[NUM_THREADS-1:0] = thread_full;
  end

  always_comb begin
    cand     = (state == PKT) ? tgt : (auto_mode ? rr_ptr : thread_sel);
    cand_ok  = ({1'b0, cand} < (SEL_W + 1)'(NUM_THREADS));
    cand_hot = NUM_THREADS'(1) << cand;
    rot_idx  = (cand == '0) ? SEL_W'(NUM_THREADS - 1) : cand - SEL_W'(1);
    rot_hot  = NUM_THREADS'(1) << rot_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    strobe       = '0;
    first_strobe = '0;
    start        = 1'b0;
    pkt_end      = 1'b0;
    bad_start    = 1'b0;
    ready_out    = ~reset & cand_ok & ~full_pad[cand];
    accept       = fifowrite_in & ready_out;
    case (state)
      IDLE: begin
        bad_start = fifowrite_in & firstword_in & ~cand_ok;
        // Words arriving outside a packet without firstword_in are dropped.
        if (accept && firstword_in) begin
          start        = 1'b1;
          strobe       = cand_hot;
          first_strobe = cand_hot;
          if (lastword_in) pkt_end   = 1'b1;
          else             state_nxt = PKT;
        end
      end
      PKT: begin
        if (accept) begin
          strobe = cand_hot;
          if (lastword_in) begin
            pkt_end   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The round-robin pointer only moves for packets that were started in auto mode.
  assign advance_rr = pkt_end & (start ? auto_mode : auto_latched);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      tgt          <= '0;
      cur_thread   <= '0;
      auto_latched <= 1'b0;
      sel_err      <= 1'b0;
    end else begin
      sel_err <= bad_start;
      if (start) begin
        tgt          <= cand;
        cur_thread   <= cand;
        auto_latched <= auto_mode;
      end
      if (advance_rr)
        rr_ptr <= (rr_ptr == SEL_W'(NUM_THREADS - 1)) ? '0 : rr_ptr + SEL_W'(1);
    end
  end

  assign firstword_out  = first_strobe;
  assign enable_cpu_out = (~reset & cand_ok & enable_cpu_in) ? rot_hot : '0;

`ifdef INFIFO_WR_STRETCH_EN
  logic [NUM_THREADS-1:0] strobe_q;

  always_ff @(posedge clk) begin
    if (reset) strobe_q <= '0;
    else       strobe_q <= strobe;
  end

  assign fifowrite_out = reset ? '0 : (strobe | strobe_q);
`else
  assign fifowrite_out = strobe;
`endif

endmodule

// File: tb/tb_infifo_dispatch.sv
// Randomized bench for infifo_dispatch: an 8-thread and a 6-thread instance share stimulus and are checked against a per-cycle reference model.
module tb_infifo_dispatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, firstword_in, fifowrite_in, lastword_in, enable_cpu_in, auto_mode;
  logic [2:0] thread_sel;
  logic [7:0] full8;
  logic [5:0] full6;
  assign full6 = full8[5:0];

  logic [7:0] fw8, wr8, en8;
  logic       rdy8, se8;
  logic [2:0] cur8;
  logic [5:0] fw6, wr6, en6;
  logic       rdy6, se6;
  logic [2:0] cur6;

  infifo_dispatch #(.NUM_THREADS(8), .SEL_W(3)) dut8 (
    .clk(clk), .reset(reset), .firstword_in(firstword_in), .fifowrite_in(fifowrite_in),
    .lastword_in(lastword_in), .enable_cpu_in(enable_cpu_in), .thread_sel(thread_sel),
    .auto_mode(auto_mode), .thread_full(full8), .firstword_out(fw8), .fifowrite_out(wr8),
    .enable_cpu_out(en8), .ready_out(rdy8), .cur_thread(cur8), .sel_err(se8));

  infifo_dispatch #(.NUM_THREADS(6), .SEL_W(3)) dut6 (
    .clk(clk), .reset(reset), .firstword_in(firstword_in), .fifowrite_in(fifowrite_in),
    .lastword_in(lastword_in), .enable_cpu_in(enable_cpu_in), .thread_sel(thread_sel),
    .auto_mode(auto_mode), .thread_full(full6), .firstword_out(fw6), .fifowrite_out(wr6),
    .enable_cpu_out(en6), .ready_out(rdy6), .cur_thread(cur6), .sel_err(se6));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per instance, whether a packet is open, its thread,
  // the round-robin pointer and the registered outputs.
  int ns[2] = '{8, 6};
  bit m_inpkt[2], m_autos[2], m_se[2];
  int m_tgt[2], m_rr[2], m_cur[2], m_prev[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_inpkt[k] = 0; m_autos[k] = 0; m_se[k] = 0;
      m_tgt[k] = 0; m_rr[k] = 0; m_cur[k] = 0; m_prev[k] = 0;
    end
  endtask

  task automatic step();
    for (int k = 0; k < 2; k++) begin
      int n, cand, strobe, first, en, wr_exp;
      bit ok, rdy, acc;
      logic [31:0] g_fw, g_wr, g_en, g_rdy, g_cur, g_se;
      n      = ns[k];
      cand   = m_inpkt[k] ? m_tgt[k] : (auto_mode ? m_rr[k] : int'(thread_sel));
      ok     = cand < n;
      rdy    = !reset && ok && !full8[cand];
      acc    = fifowrite_in && rdy;
      strobe = 0;
      first  = 0;
      if (acc && (m_inpkt[k] || firstword_in)) strobe = 1 << cand;
      if (acc && !m_inpkt[k] && firstword_in) first = 1 << cand;
      en = (!reset && ok && enable_cpu_in) ? (1 << ((cand + n - 1) % n)) : 0;
`ifdef INFIFO_WR_STRETCH_EN
      wr_exp = reset ? 0 : (strobe | m_prev[k]);
`else
      wr_exp = strobe;
`endif
      if (k == 0) begin
        g_fw = 32'(fw8); g_wr = 32'(wr8); g_en = 32'(en8);
        g_rdy = 32'(rdy8); g_cur = 32'(cur8); g_se = 32'(se8);
      end else begin
        g_fw = 32'(fw6); g_wr = 32'(wr6); g_en = 32'(en6);
        g_rdy = 32'(rdy6); g_cur = 32'(cur6); g_se = 32'(se6);
      end
      check($sformatf("n%0d_ready", n), g_rdy, 32'(rdy));
      check($sformatf("n%0d_firstword", n), g_fw, 32'(first));
      check($sformatf("n%0d_fifowrite", n), g_wr, 32'(wr_exp));
      check($sformatf("n%0d_enable_cpu", n), g_en, 32'(en));
      check($sformatf("n%0d_cur_thread", n), g_cur, 32'(m_cur[k]));
      check($sformatf("n%0d_sel_err", n), g_se, 32'(m_se[k]));

      if (reset) begin
        m_inpkt[k] = 0; m_autos[k] = 0; m_se[k] = 0;
        m_tgt[k] = 0; m_rr[k] = 0; m_cur[k] = 0; m_prev[k] = 0;
      end else begin
        m_se[k]   = fifowrite_in && firstword_in && !m_inpkt[k] && !ok;
        m_prev[k] = strobe;
        if (acc && !m_inpkt[k] && firstword_in) begin
          m_tgt[k] = cand; m_cur[k] = cand; m_autos[k] = auto_mode;
          if (lastword_in) begin
            if (auto_mode) m_rr[k] = (m_rr[k] + 1) % n;
          end else begin
            m_inpkt[k] = 1;
          end
        end else if (acc && m_inpkt[k] && lastword_in) begin
          m_inpkt[k] = 0;
          if (m_autos[k]) m_rr[k] = (m_rr[k] + 1) % n;
        end
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit fw, input bit wr, input bit lw, input bit en,
                       input int sel, input bit am, input logic [7:0] full);
    @(posedge clk);
    #1;
    reset = rst; firstword_in = fw; fifowrite_in = wr; lastword_in = lw;
    enable_cpu_in = en; thread_sel = 3'(sel); auto_mode = am; full8 = full;
    @(negedge clk);
    step();
  endtask

  initial begin
    reset = 1; firstword_in = 0; fifowrite_in = 0; lastword_in = 0;
    enable_cpu_in = 0; thread_sel = 0; auto_mode = 0; full8 = 0;
    repeat (2) @(posedge clk);
    model_reset();
    cycle(1, 0, 0, 0, 1, 0, 0, 8'h00);

    // 4-word packet to thread 5, then an idle cycle to see cur_thread.
    cycle(0, 1, 1, 0, 0, 5, 0, 8'h00);
    cycle(0, 0, 1, 0, 0, 5, 0, 8'h00);
    cycle(0, 1, 1, 0, 0, 5, 0, 8'h00);
    cycle(0, 0, 1, 1, 0, 5, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 5, 0, 8'h00);

    // Round-robin single-word packets through a full wrap of the 8-thread pointer.
    cycle(1, 0, 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 1, 1, 0, 1, 8'h00);

    // Full thread blocks the write, then clears.
    cycle(0, 1, 1, 0, 0, 3, 0, 8'h08);
    cycle(0, 1, 1, 1, 0, 3, 0, 8'h00);

    // Select change mid-packet is ignored; CPU enable rotation at thread 0.
    cycle(0, 1, 1, 0, 0, 2, 0, 8'h00);
    cycle(0, 0, 1, 0, 1, 6, 0, 8'h00);
    cycle(0, 0, 1, 1, 1, 6, 1, 8'h00);
    cycle(0, 0, 0, 0, 1, 0, 0, 8'h00);

    // Illegal select on the 6-thread instance, then reset mid-packet.
    cycle(0, 1, 1, 0, 0, 7, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 7, 0, 8'h00);
    cycle(0, 1, 1, 0, 0, 4, 0, 8'h00);
    cycle(1, 0, 1, 0, 1, 4, 0, 8'h00);
    cycle(0, 0, 1, 0, 0, 4, 0, 8'h00);
    cycle(0, 1, 1, 0, 0, 4, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 4, 0, 8'h00);

    begin
      bit am = 0;
      for (int i = 0; i < 3000; i++) begin
        logic [7:0] full = '0;
        for (int b = 0; b < 8; b++) full[b] = ($urandom_range(0, 99) < 15);
        if ($urandom_range(0, 9) == 0) am = ~am;
        cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), am, full);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/infifo_dispatch.md
INFIFO_DISPATCH -- requirements
Module: infifo_dispatch

Interface
REQ-001 Parameter NUM_THREADS, default 8: number of per-thread input FIFOs; legal range 2..16.
REQ-002 Parameter SEL_W, default 3: thread-select width; SHALL satisfy 2**SEL_W >= NUM_THREADS.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 firstword_in  input  1  first word of a packet present on the write path.
REQ-006 fifowrite_in  input  1  write strobe from the packet source.
REQ-007 lastword_in  input  1  last word of a packet; qualified by fifowrite_in.
REQ-008 enable_cpu_in  input  1  CPU enable request for the selected thread.
REQ-009 thread_sel  input  SEL_W  explicit target thread, used when auto_mode=0.
REQ-010 auto_mode  input  1  1 = round-robin target selection; 0 = thread_sel.
REQ-011 thread_full  input  NUM_THREADS  per-thread FIFO full flags.
REQ-012 firstword_out  output  NUM_THREADS  one-hot first-word strobe to the target FIFO.
REQ-013 fifowrite_out  output  NUM_THREADS  one-hot write strobe to the target FIFO.
REQ-014 enable_cpu_out  output  NUM_THREADS  CPU enable, rotated: target t drives bit (t+NUM_THREADS-1) mod NUM_THREADS.
REQ-015 ready_out  output  1  source may write this cycle.
REQ-016 cur_thread  output  SEL_W  registered target of the packet in progress, or of the last packet.
REQ-017 sel_err  output  1  one-cycle pulse when a packet start is rejected for an illegal select.

Function
REQ-018 FSM states IDLE and PKT only; reset state IDLE.
REQ-019 Candidate target: IDLE -> auto_mode ? rr_ptr : thread_sel; PKT -> latched target.
REQ-020 ready_out = ~thread_full[candidate], combinational; forced 0 when the candidate is >= NUM_THREADS.
REQ-021 A write is accepted only when fifowrite_in && ready_out; no output strobe otherwise; the source holds the word.
REQ-022 IDLE: accepted write with firstword_in latches the candidate, asserts firstword_out[candidate] and fifowrite_out[candidate] in the same cycle (zero latency), moves to PKT.
REQ-023 IDLE: accepted write without firstword_in is discarded; no strobe; state unchanged.
REQ-024 PKT: accepted write drives fifowrite_out[latched] only; thread_sel and auto_mode changes are ignored until the packet ends.
REQ-025 PKT: firstword_in during an accepted write is treated as a normal word (firstword_out stays 0).
REQ-026 Accepted write with lastword_in ends the packet -> IDLE next cycle; rr_ptr advances by 1, wrapping NUM_THREADS-1 -> 0, only if auto_mode was 1 at packet start.
REQ-027 Single-word packet (firstword_in && lastword_in in IDLE): strobes issued, state stays IDLE, rr_ptr advances per REQ-026.
REQ-028 Packet start with thread_sel >= NUM_THREADS (auto_mode=0): no strobe, state IDLE, sel_err pulses 1 for one cycle.
REQ-029 enable_cpu_out: combinational, enable_cpu_in gated to the rotated bit of the current candidate; all 0 if the candidate is illegal.
REQ-030 cur_thread updates one cycle after the packet-start write.

Reset
REQ-031 Reset: state IDLE, rr_ptr 0, cur_thread 0, stretch register 0, sel_err 0.
REQ-032 While reset is high, firstword_out, fifowrite_out and enable_cpu_out are 0 and ready_out is 0.
REQ-033 Reset mid-packet abandons the packet; the next accepted word requires firstword_in.

Configuration
REQ-034 Macro INFIFO_WR_STRETCH_EN defined: fifowrite_out[i] = current strobe OR the strobe registered from the previous cycle (two-cycle write pulse per word); the registered copy is cleared by reset.
REQ-035 Macro undefined: fifowrite_out is the single-cycle strobe only; no stretch register is built.

Verification
REQ-036 auto_mode=0, thread_sel=5, 4-word packet -> firstword_out=0x20 on word 1 only, fifowrite_out=0x20 on 4 cycles, cur_thread=5.
REQ-037 auto_mode=1, three 1-word packets from reset -> targets 0,1,2; after packet at rr_ptr=7 (N=8) the next target is 0.
REQ-038 thread_full[3]=1, thread_sel=3, write pending -> ready_out=0, no strobes; clear full -> write accepted that cycle.
REQ-039 thread_sel changed 2->6 mid-packet -> remaining words still strobe fifowrite_out[2]; enable_cpu_in with sel=0 in IDLE -> enable_cpu_out=0x80.
REQ-040 NUM_THREADS=6, thread_sel=7 packet start -> sel_err pulse, no strobes; reset asserted mid-packet -> outputs 0, IDLE; with INFIFO_WR_STRETCH_EN a 1-cycle write shows a 2-cycle fifowrite_out pulse.
